// File: rtl/sm83_decode_queue.sv
// SM83 instruction assembler + decoder feeding a DEPTH-entry queue of decoded control records.
// Optional CB-prefix handling is enabled by defining SM83_CB_PREFIX_EN.
module sm83_decode_queue #(
    parameter int DEPTH   = 4,
    parameter int STATE_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               byte_in,
    input  logic                     byte_valid,
    output logic                     byte_ready,
    input  logic                     flush,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [7:0]               dec_opcode,
    output logic                     dec_cb,
    output logic [3:0]               dec_ld_reg,
    output logic [1:0]               dec_ptr_reg,
    output logic [STATE_W-1:0]       dec_next_state,
    output logic [15:0]              dec_reset_vec,
    output logic [15:0]              dec_imm,
    output logic [1:0]               dec_len,
    output logic                     dec_illegal,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [STATE_W-1:0] ST_RESET    = STATE_W'(16'hff00);
    localparam logic [STATE_W-1:0] ST_FETCH_A  = STATE_W'(16'hff05);
    localparam logic [STATE_W-1:0] ST_LD_IMM_C = STATE_W'(16'hff0b);
    localparam logic [STATE_W-1:0] ST_LD_A16_A = STATE_W'(16'hff0c);
    localparam logic [STATE_W-1:0] ST_JP_IMM_A = STATE_W'(16'hff0f);
    localparam logic [STATE_W-1:0] ST_CB_A     = STATE_W'(16'hff10);

    typedef struct packed {
        logic [7:0]         opcode;
        logic               cb;
        logic [3:0]         ld_reg;
        logic [1:0]         ptr_reg;
        logic [STATE_W-1:0] next_state;
        logic [15:0]        reset_vec;
        logic [15:0]        imm;
        logic [1:0]         len;
        logic               illegal;
    } rec_t;

    typedef enum logic [1:0] {
        S_OPC,
        S_IMM_LO,
        S_IMM_HI
`ifdef SM83_CB_PREFIX_EN
        , S_CB
`endif
    } state_t;

    function automatic logic is_ld_d8(input logic [7:0] op);
        return op[7:6] == 2'b00 && op[2:0] == 3'b110 && op[5:3] != 3'b110;
    endfunction

    function automatic logic is_ld_hl(input logic [7:0] op);
        return op[7:6] == 2'b01 && op[2:0] == 3'b110 && op[5:3] != 3'b110;
    endfunction

    // Opcode register field (b,c,d,e,h,l,-,a) to the control register enum (a=0 ... l=7).
    function automatic logic [3:0] reg_enum(input logic [2:0] code);
        case (code)
            3'd0:    return 4'd1;
            3'd1:    return 4'd2;
            3'd2:    return 4'd3;
            3'd3:    return 4'd4;
            3'd4:    return 4'd6;
            3'd5:    return 4'd7;
            default: return 4'd0;
        endcase
    endfunction

    function automatic rec_t decode(input logic [7:0] op, input logic cb,
                                    input logic [7:0] lo, input logic [7:0] hi);
        rec_t r;
        r            = '0;
        r.opcode     = op;
        r.next_state = ST_FETCH_A;
        r.len        = 2'd1;
        if (cb) begin
            r.cb         = 1'b1;
            r.next_state = ST_CB_A;
            r.len        = 2'd2;
        end else if (is_ld_d8(op)) begin
            r.next_state = ST_LD_IMM_C;
            r.ld_reg     = reg_enum(op[5:3]);
            r.imm        = {8'h00, lo};
            r.len        = 2'd2;
        end else if (op == 8'hc3) begin
            r.next_state = ST_JP_IMM_A;
            r.ld_reg     = 4'hb;
            r.imm        = {hi, lo};
            r.len        = 2'd3;
        end else if (is_ld_hl(op)) begin
            r.next_state = ST_LD_A16_A;
            r.ptr_reg    = 2'd2;
        end else if (op[7:6] == 2'b11 && op[2:0] == 3'b111) begin
            r.next_state = ST_RESET;
            r.reset_vec  = {8'h00, 2'b00, op[5:3], 3'b000};
        end else if (op != 8'h00) begin
            r.illegal = 1'b1;
        end
        return r;
    endfunction

    state_t          state, state_nxt;
    logic            need2, need2_nxt;
    logic [7:0]      op_q, op_nxt;
    logic [7:0]      lo_q, lo_nxt;
    rec_t            mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    rec_t            rec_in, head;
    logic            accept, push, pop;

    assign byte_ready = !rst && !flush && (count != CW'(DEPTH));
    assign accept     = byte_valid && byte_ready;
    assign dec_valid  = count != '0;
    assign pop        = dec_valid && dec_ready;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        need2_nxt = need2;
        op_nxt    = op_q;
        lo_nxt    = lo_q;
        push      = 1'b0;
        rec_in    = decode(byte_in, 1'b0, 8'h00, 8'h00);
        if (accept) begin
            case (state)
                S_OPC: begin
                    op_nxt = byte_in;
`ifdef SM83_CB_PREFIX_EN
                    if (byte_in == 8'hcb) state_nxt = S_CB; else
`endif
                    if (is_ld_d8(byte_in)) begin
                        state_nxt = S_IMM_LO;
                        need2_nxt = 1'b0;
                    end else if (byte_in == 8'hc3) begin
                        state_nxt = S_IMM_LO;
                        need2_nxt = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
                S_IMM_LO: begin
                    if (need2) begin
                        lo_nxt    = byte_in;
                        state_nxt = S_IMM_HI;
                    end else begin
                        push      = 1'b1;
                        rec_in    = decode(op_q, 1'b0, byte_in, 8'h00);
                        state_nxt = S_OPC;
                    end
                end
                S_IMM_HI: begin
                    push      = 1'b1;
                    rec_in    = decode(op_q, 1'b0, lo_q, byte_in);
                    state_nxt = S_OPC;
                end
`ifdef SM83_CB_PREFIX_EN
                S_CB: begin
                    push      = 1'b1;
                    rec_in    = decode(byte_in, 1'b1, 8'h00, 8'h00);
                    state_nxt = S_OPC;
                end
`endif
                default: state_nxt = S_OPC;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_OPC;
            need2  <= 1'b0;
            op_q   <= '0;
            lo_q   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // NOTE: the record storage is cleared on reset because the head entry is visible on dec_*.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            state  <= S_OPC;
            need2  <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_nxt;
            need2 <= need2_nxt;
            op_q  <= op_nxt;
            lo_q  <= lo_nxt;
            if (push) begin
                mem[wr_ptr] <= rec_in;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head           = dec_valid ? mem[rd_ptr] : '0;
    assign dec_opcode     = head.opcode;
    assign dec_cb         = head.cb;
    assign dec_ld_reg     = head.ld_reg;
    assign dec_ptr_reg    = head.ptr_reg;
    assign dec_next_state = head.next_state;
    assign dec_reset_vec  = head.reset_vec;
    assign dec_imm        = head.imm;
    assign dec_len        = head.len;
    assign dec_illegal    = head.illegal;

endmodule

// File: tb/tb_sm83_decode_queue.sv
// Self-checking bench for sm83_decode_queue: directed table, corner sequences, randomized model compare.
module tb_sm83_decode_queue;

    localparam int DEPTH = 4;
    localparam int PW    = 66;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        flush;
    logic        dec_valid;
    logic        dec_ready;
    logic [7:0]  dec_opcode;
    logic        dec_cb;
    logic [3:0]  dec_ld_reg;
    logic [1:0]  dec_ptr_reg;
    logic [15:0] dec_next_state;
    logic [15:0] dec_reset_vec;
    logic [15:0] dec_imm;
    logic [1:0]  dec_len;
    logic        dec_illegal;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    sm83_decode_queue #(.DEPTH(DEPTH), .STATE_W(16)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .flush(flush), .dec_valid(dec_valid),
        .dec_ready(dec_ready), .dec_opcode(dec_opcode), .dec_cb(dec_cb),
        .dec_ld_reg(dec_ld_reg), .dec_ptr_reg(dec_ptr_reg),
        .dec_next_state(dec_next_state), .dec_reset_vec(dec_reset_vec),
        .dec_imm(dec_imm), .dec_len(dec_len), .dec_illegal(dec_illegal),
        .count(count)
    );

    always #5 clk = ~clk;

    logic [PW-1:0] dut_rec;
    assign dut_rec = {dec_opcode, dec_cb, dec_ld_reg, dec_ptr_reg, dec_next_state,
                      dec_reset_vec, dec_imm, dec_len, dec_illegal};

    function automatic logic [PW-1:0] mk(input logic [7:0] op, input logic cb,
                                         input logic [3:0] ld, input logic [1:0] ptr,
                                         input logic [15:0] ns, input logic [15:0] rv,
                                         input logic [15:0] imm, input logic [1:0] len,
                                         input logic ill);
        return {op, cb, ld, ptr, ns, rv, imm, len, ill};
    endfunction

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock with the given inputs held, then inputs idle and outputs settled.
    task automatic apply(input logic v, input logic [7:0] b, input logic r, input logic f);
        byte_valid = v; byte_in = b; dec_ready = r; flush = f;
        @(posedge clk); #1;
        byte_valid = 1'b0; byte_in = 8'h00; dec_ready = 1'b0; flush = 1'b0;
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic bit cb_enabled();
`ifdef SM83_CB_PREFIX_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int instr_len(input logic [7:0] op);
        if (op == 8'hcb && cb_enabled()) return 2;
        if (op inside {8'h06, 8'h0e, 8'h16, 8'h1e, 8'h26, 8'h2e, 8'h3e}) return 2;
        if (op == 8'hc3) return 3;
        return 1;
    endfunction

    function automatic logic [3:0] dest_of(input logic [7:0] op);
        case (op)
            8'h06:   return 4'd1;
            8'h0e:   return 4'd2;
            8'h16:   return 4'd3;
            8'h1e:   return 4'd4;
            8'h26:   return 4'd6;
            8'h2e:   return 4'd7;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [PW-1:0] model_rec(input logic [7:0] b [$]);
        logic [7:0] op;
        op = b[0];
        if (op == 8'hcb && cb_enabled())
            return mk(b[1], 1'b1, 4'd0, 2'd0, 16'hff10, 16'h0, 16'h0, 2'd2, 1'b0);
        if (instr_len(op) == 2)
            return mk(op, 1'b0, dest_of(op), 2'd0, 16'hff0b, 16'h0, {8'h00, b[1]}, 2'd2, 1'b0);
        if (op == 8'hc3)
            return mk(op, 1'b0, 4'hb, 2'd0, 16'hff0f, 16'h0, {b[2], b[1]}, 2'd3, 1'b0);
        if (op inside {8'h46, 8'h4e, 8'h56, 8'h5e, 8'h66, 8'h6e, 8'h7e})
            return mk(op, 1'b0, 4'd0, 2'd2, 16'hff0c, 16'h0, 16'h0, 2'd1, 1'b0);
        if (op inside {8'hc7, 8'hcf, 8'hd7, 8'hdf, 8'he7, 8'hef, 8'hf7, 8'hff})
            return mk(op, 1'b0, 4'd0, 2'd0, 16'hff00, {8'h00, op & 8'h38}, 16'h0, 2'd1, 1'b0);
        return mk(op, 1'b0, 4'd0, 2'd0, 16'hff05, 16'h0, 16'h0, 2'd1, op != 8'h00);
    endfunction

    function automatic logic [7:0] pick_byte();
        logic [7:0] menu [10];
        menu = '{8'h00, 8'h3e, 8'h06, 8'h2e, 8'hc3, 8'h7e, 8'hdf, 8'hcb, 8'h76, 8'hff};
        if ($urandom_range(0, 3) == 0) return 8'($urandom);
        return menu[$urandom_range(0, 9)];
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        string         name;
        int            n;
        logic [7:0]    b0, b1, b2;
        logic [PW-1:0] exp;
    } vec_t;

    vec_t vecs [$];

    logic [PW-1:0] mq [$];
    logic [7:0]    pend [$];

    initial begin
        logic [PW-1:0] rec_0;
        rst = 1'b1; byte_in = 8'h00; byte_valid = 1'b0; flush = 1'b0; dec_ready = 1'b0;

        vecs.push_back('{"ld_a_d8",  2, 8'h3e, 8'h42, 8'h00, mk(8'h3e, 0, 4'd0, 2'd0, 16'hff0b, 16'h0,    16'h0042, 2'd2, 0)});
        vecs.push_back('{"jp_a16",   3, 8'hc3, 8'h34, 8'h12, mk(8'hc3, 0, 4'hb, 2'd0, 16'hff0f, 16'h0,    16'h1234, 2'd3, 0)});
        vecs.push_back('{"rst_18",   1, 8'hdf, 8'h00, 8'h00, mk(8'hdf, 0, 4'd0, 2'd0, 16'hff00, 16'h0018, 16'h0,    2'd1, 0)});
        vecs.push_back('{"rst_00",   1, 8'hc7, 8'h00, 8'h00, mk(8'hc7, 0, 4'd0, 2'd0, 16'hff00, 16'h0000, 16'h0,    2'd1, 0)});
        vecs.push_back('{"rst_38",   1, 8'hff, 8'h00, 8'h00, mk(8'hff, 0, 4'd0, 2'd0, 16'hff00, 16'h0038, 16'h0,    2'd1, 0)});
        vecs.push_back('{"nop",      1, 8'h00, 8'h00, 8'h00, mk(8'h00, 0, 4'd0, 2'd0, 16'hff05, 16'h0,    16'h0,    2'd1, 0)});
        vecs.push_back('{"ld_a_hl",  1, 8'h7e, 8'h00, 8'h00, mk(8'h7e, 0, 4'd0, 2'd2, 16'hff0c, 16'h0,    16'h0,    2'd1, 0)});
        vecs.push_back('{"ld_b_hl",  1, 8'h46, 8'h00, 8'h00, mk(8'h46, 0, 4'd0, 2'd2, 16'hff0c, 16'h0,    16'h0,    2'd1, 0)});
        vecs.push_back('{"ld_b_d8",  2, 8'h06, 8'hff, 8'h00, mk(8'h06, 0, 4'd1, 2'd0, 16'hff0b, 16'h0,    16'h00ff, 2'd2, 0)});
        vecs.push_back('{"ld_l_d8",  2, 8'h2e, 8'h80, 8'h00, mk(8'h2e, 0, 4'd7, 2'd0, 16'hff0b, 16'h0,    16'h0080, 2'd2, 0)});
        vecs.push_back('{"halt_ill", 1, 8'h76, 8'h00, 8'h00, mk(8'h76, 0, 4'd0, 2'd0, 16'hff05, 16'h0,    16'h0,    2'd1, 1)});
        vecs.push_back('{"e3_ill",   1, 8'he3, 8'h00, 8'h00, mk(8'he3, 0, 4'd0, 2'd0, 16'hff05, 16'h0,    16'h0,    2'd1, 1)});

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset byte_ready", byte_ready, 0);
        check("reset dec_valid", dec_valid, 0);
        check("reset count", count, 0);
        check("reset dec_fields", dut_rec, 0);
        rst = 1'b0;
        #1;
        check("post-reset byte_ready", byte_ready, 1);

        // Table: feed each instruction with the queue held, check the head, then pop it.
        foreach (vecs[i]) begin
            logic [7:0] bs [3];
            bs = '{vecs[i].b0, vecs[i].b1, vecs[i].b2};
            for (int k = 0; k < vecs[i].n; k++) begin
                check({vecs[i].name, " valid before last byte"}, dec_valid, 0);
                apply(1'b1, bs[k], 1'b0, 1'b0);
            end
            check({vecs[i].name, " dec_valid latency"}, dec_valid, 1);
            check({vecs[i].name, " record"}, dut_rec, vecs[i].exp);
            apply(1'b0, 8'h00, 1'b1, 1'b0);
            check({vecs[i].name, " count after pop"}, count, 0);
        end

        // Fill to DEPTH with nops, then pop one and refill.
        repeat (6) apply(1'b1, 8'h00, 1'b0, 1'b0);
        check("full count", count, DEPTH);
        check("full byte_ready", byte_ready, 0);
        apply(1'b0, 8'h00, 1'b1, 1'b0);
        check("pop from full count", count, 3);
        check("pop from full byte_ready", byte_ready, 1);
        apply(1'b1, 8'h00, 1'b0, 1'b0);
        check("refill count", count, DEPTH);
        // Full with simultaneous pop and byte: push rejected that cycle.
        apply(1'b1, 8'h00, 1'b1, 1'b0);
        check("full pop+push count", count, 3);
        apply(1'b0, 8'h00, 1'b0, 1'b1);
        check("flush empties queue", count, 0);

        // Flush mid-JP with the operand byte in flight.
        apply(1'b1, 8'h00, 1'b0, 1'b0);
        apply(1'b1, 8'hc3, 1'b0, 1'b0);
        apply(1'b1, 8'h34, 1'b0, 1'b0);
        byte_valid = 1'b1; byte_in = 8'h12; flush = 1'b1;
        #1;
        check("flush byte_ready low", byte_ready, 0);
        @(posedge clk); #1;
        byte_valid = 1'b0; flush = 1'b0; byte_in = 8'h00;
        #1;
        check("after flush count", count, 0);
        check("after flush dec_valid", dec_valid, 0);
        check("after flush byte_ready", byte_ready, 1);
        apply(1'b1, 8'h7e, 1'b0, 1'b0);
        check("fresh opcode after flush", dut_rec,
              mk(8'h7e, 0, 4'd0, 2'd2, 16'hff0c, 16'h0, 16'h0, 2'd1, 0));
        check("fresh opcode count", count, 1);
        apply(1'b0, 8'h00, 1'b1, 1'b0);

        // CB prefix handling
        apply(1'b1, 8'hcb, 1'b0, 1'b0);
        apply(1'b1, 8'h37, 1'b0, 1'b0);
`ifdef SM83_CB_PREFIX_EN
        check("cb count", count, 1);
        check("cb record", dut_rec, mk(8'h37, 1, 4'd0, 2'd0, 16'hff10, 16'h0, 16'h0, 2'd2, 0));
`else
        check("no-cb count", count, 2);
        check("no-cb first record", dut_rec, mk(8'hcb, 0, 4'd0, 2'd0, 16'hff05, 16'h0, 16'h0, 2'd1, 1));
        apply(1'b0, 8'h00, 1'b1, 1'b0);
        check("no-cb second record", dut_rec, mk(8'h37, 0, 4'd0, 2'd0, 16'hff05, 16'h0, 16'h0, 2'd1, 1));
`endif
        apply(1'b0, 8'h00, 1'b0, 1'b1);

        // Reset mid-JP with a record queued.
        apply(1'b1, 8'h3e, 1'b0, 1'b0);
        apply(1'b1, 8'h55, 1'b0, 1'b0);
        apply(1'b1, 8'hc3, 1'b0, 1'b0);
        apply(1'b1, 8'h34, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid-JP reset count", count, 0);
        check("mid-JP reset dec_valid", dec_valid, 0);
        check("mid-JP reset byte_ready", byte_ready, 0);
        check("mid-JP reset fields", dut_rec, 0);
        rst = 1'b0;
        #1;
        apply(1'b1, 8'h00, 1'b0, 1'b0);
        rec_0 = mk(8'h00, 0, 4'd0, 2'd0, 16'hff05, 16'h0, 16'h0, 2'd1, 0);
        check("opcode after reset", dut_rec, rec_0);
        apply(1'b0, 8'h00, 1'b0, 1'b1);

        // Randomized traffic against the byte-queue model.
        mq.delete();
        pend.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic       v, r, f, exp_br;
            logic [7:0] b;
            v = $urandom_range(0, 3) != 0;
            b = pick_byte();
            r = ((cyc / 200) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
            f = $urandom_range(0, 149) == 0;
            byte_valid = v; byte_in = b; dec_ready = r; flush = f;
            #1;
            exp_br = !f && mq.size() != DEPTH;
            check("rand byte_ready", byte_ready, exp_br);
            check("rand dec_valid", dec_valid, mq.size() != 0);
            check("rand count", count, mq.size());
            if (mq.size() != 0) check("rand head record", dut_rec, mq[0]);
            if (f) begin
                mq.delete();
                pend.delete();
            end else begin
                if (r && mq.size() != 0) void'(mq.pop_front());
                if (v && exp_br) begin
                    pend.push_back(b);
                    if (pend.size() == instr_len(pend[0])) begin
                        mq.push_back(model_rec(pend));
                        pend.delete();
                    end
                end
            end
            @(posedge clk); #1;
        end
        byte_valid = 1'b0; dec_ready = 1'b0; flush = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sm83_decode_queue.md
# sm83_decode_queue

Registered successor to the combinational opcode decoder: it accepts the raw instruction byte stream from the fetch path, assembles complete instructions (opcode, optional 0xCB prefix, 0–2 operand bytes), decodes each into a control record and buffers records in a DEPTH-entry FIFO. The control FSM pops one fully-formed instruction per handshake instead of re-entering `inc_pc`/`load_byte_imm` states to gather operands. It sits between the memory fetch interface and `control`.

## Interface
- `DEPTH`, 4, decoded-record FIFO entries; power of two, ≥2.
- `STATE_W`, 16, width of state codes; must match `control`.

- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `byte_in`  in  8  instruction byte from fetch
- `byte_valid`  in  1  `byte_in` valid
- `byte_ready`  out  1  byte accepted when `byte_valid && byte_ready`
- `flush`  in  1  discard partial instruction and all queued records (taken jump/rst)
- `dec_valid`  out  1  head record valid
- `dec_ready`  in  1  control pops head when `dec_valid && dec_ready`
- `dec_opcode`  out  8  opcode (second byte for CB-prefixed)
- `dec_cb`  out  1  instruction was 0xCB-prefixed
- `dec_ld_reg`  out  4  destination register enum (a=0 … l=7, pc=0xb)
- `dec_ptr_reg`  out  2  pointer pair enum (bc=0, de=1, hl=2)
- `dec_next_state`  out  STATE_W  control state to enter
- `dec_reset_vec`  out  16  rst target
- `dec_imm`  out  16  operand, little-endian; d8 zero-extended
- `dec_len`  out  2  total bytes consumed (1–3)
- `dec_illegal`  out  1  opcode undefined in this table
- `count`  out  $clog2(DEPTH)+1  records queued

## Operation
- Assembler FSM states: OPC, CB, IMM_LO, IMM_HI. Advances only on accepted byte.
  - OPC: 0xCB → CB; LD r,d8 (06/0e/16/1e/26/2e/3e) → IMM_LO, need=1; JP a16 (c3) → IMM_LO, need=2; else complete.
  - CB: any byte completes (`dec_cb`=1, len 2).
  - IMM_LO: need=1 completes; need=2 → IMM_HI. IMM_HI completes.
- Completion pushes one record; FSM returns to OPC.
- Decode table (next_state):
  - 00 nop: fetch_a (0xff05), len 1.
  - LD r,d8: load_byte_imm_c (0xff0b), `dec_ld_reg`=r, imm={8'h00,d8}, len 2.
  - LD r,(HL) (46/4e/56/5e/66/6e/7e): load_byte_a16_a (0xff0c), ptr=hl, len 1.
  - RST (c7,cf,d7,df,e7,ef,f7,ff): reset (0xff00), `dec_reset_vec`={8'h00,2'b00,op[5:3],3'b000}, len 1.
  - JP a16: jp_imm16_a (0xff0f), ld_reg=pc, imm={hi,lo}, len 3.
  - CB-prefixed: cb_a (0xff10), len 2.
  - Other: fetch_a, `dec_illegal`=1, len 1.
- Unused record fields are 0.
- `byte_ready` = !rst && !flush && (count != DEPTH). It is conservative: mid-instruction bytes also stall while full.
- FIFO: simultaneous push and pop allowed at any occupancy below full; count unchanged. At full, a pop frees a slot the following cycle.
- `flush` beats push and pop in the same cycle: count→0, FSM→OPC, in-flight byte dropped, head pointer reset.
- `rst` mid-instruction behaves like `flush` and additionally zeroes storage.

## Timing
- Reset values: `dec_valid`=0, `byte_ready`=0, `count`=0, all `dec_*`=0, FSM=OPC.
- Latency: last byte accepted in cycle N → record visible, `dec_valid`=1 in N+1 (empty queue).
- `dec_*` are driven combinationally from the registered head entry. They are stable while `dec_valid && !dec_ready`.
- Throughput: one byte per cycle; peak one 1-byte instruction per cycle.
- The cycle after `flush` has `dec_valid`=0, `byte_ready`=1.

## Configuration
- `SM83_CB_PREFIX_EN` defined: CB state present, 0xCB handled as above.
- Not defined: no CB state. 0xCB decodes as a 1-byte illegal (fetch_a, `dec_illegal`=1), and the following byte is treated as a new opcode.

## Test plan
- Reset, then bytes 3e,42 → one record: next_state 0xff0b, ld_reg 0, imm 0x0042, len 2, `dec_valid` one cycle after 0x42 accepted.
- Bytes c3,34,12 → next_state 0xff0f, ld_reg 0xb, imm 0x1234, len 3. Bytes df → reset_vec 0x0018.
- DEPTH=4, `dec_ready`=0, stream 00×6 → count 4, `byte_ready`=0. Pop one → count 3, then 4 again next push.
- Send c3,34, assert `flush` with 0x12 valid → count 0, 0x12 dropped. Next byte 7e decodes as fresh opcode: 0xff0c, ptr 2.
- With `SM83_CB_PREFIX_EN`: cb,37 → dec_cb 1, opcode 0x37, 0xff10, len 2. Without the macro: two records, illegal 0xcb, then illegal 0x37.
- Full queue with simultaneous pop and byte_valid → push rejected that cycle, count 3 afterwards. Reset asserted mid-JP → all outputs 0 next cycle.
